// File: rtl/pipelined_cla_subtractor.sv
// pipelined_cla_subtractor: diff = a - b - borrow_in over 4-bit CLA slices, one register per slice; ports clk/rst_n, in_valid/in_ready/a/b/borrow_in, out_valid/out_ready/diff/borrow_out/overflow
module pipelined_cla_subtractor #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  borrow_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  borrow_out,
  output logic                  overflow
);
  localparam int NUM_STAGES = DATA_WIDTH / 4;
  logic                  v_q  [NUM_STAGES];
  logic                  c_q  [NUM_STAGES];
  logic                  c3_q [NUM_STAGES];
  logic [DATA_WIDTH-1:0] s_q  [NUM_STAGES];
  logic [DATA_WIDTH-1:0] y_q  [NUM_STAGES];
  logic                  adv;
  function automatic logic [5:0] cla4(input logic [3:0] u, input logic [3:0] w, input logic ci);
    logic [3:0] p, g, c;
    logic       c4;
    p    = u ^ w;
    g    = u & w;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c4, c[3], p ^ c};
  endfunction
  assign adv        = out_ready | ~v_q[NUM_STAGES-1];
  assign in_ready   = adv;
  assign out_valid  = v_q[NUM_STAGES-1];
  assign diff       = s_q[NUM_STAGES-1];
  assign borrow_out = v_q[NUM_STAGES-1] & ~c_q[NUM_STAGES-1];
  assign overflow   = c3_q[NUM_STAGES-1] ^ c_q[NUM_STAGES-1];
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_st
    logic [DATA_WIDTH-1:0] x, y, sn;
    logic                  ci, vi;
    logic [5:0]            r;
    if (k == 0) begin : g_in
      assign x  = a;
      assign y  = ~b;
      assign ci = ~borrow_in;
      assign vi = in_valid;
    end else begin : g_mid
      assign x  = s_q[k-1];
      assign y  = y_q[k-1];
      assign ci = c_q[k-1];
      assign vi = v_q[k-1];
    end
    assign r = cla4(x[4*k+:4], y[4*k+:4], ci);
    always_comb begin
      sn         = x;
      sn[4*k+:4] = r[3:0];
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v_q[k]  <= 1'b0;
        c_q[k]  <= 1'b0;
        c3_q[k] <= 1'b0;
        s_q[k]  <= '0;
        y_q[k]  <= '0;
      end else if (adv) begin
        v_q[k]  <= vi;
        c_q[k]  <= r[5];
        c3_q[k] <= r[4];
        s_q[k]  <= sn;
        y_q[k]  <= y;
      end
  end
endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// tb_pipelined_cla_subtractor: directed and scoreboarded checks of the pipelined CLA subtractor
module tb_pipelined_cla_subtractor;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, borrow_in, out_valid, out_ready, borrow_out, overflow;
  logic [15:0] a, b, diff;
  logic [31:0] q[$];
  logic [31:0] snap;
  int          checks = 0;
  int          errors = 0;
  int          npop = 0;
  int          p0;
  pipelined_cla_subtractor #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .borrow_in(borrow_in), .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
    .borrow_out(borrow_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    int s, u;
    s = int'($signed(x)) - int'($signed(y)) - int'(bi);
    u = int'(x) - int'(y) - int'(bi);
    return {14'd0, x - y - {15'd0, bi}, u < 0, (s > 32767) || (s < -32768)};
  endfunction
  function automatic logic [31:0] obs_out();
    return {14'd0, diff, borrow_out, overflow};
  endfunction
  task automatic cyc(input logic iv, input logic [15:0] ia, input logic [15:0] ib, input logic bi, input logic ordy);
    in_valid = iv; a = ia; b = ib; borrow_in = bi; out_ready = ordy;
    #1;
    if (out_valid && ordy) begin
      if (q.size() == 0) chk("spurious result", obs_out(), 32'hFFFF_FFFF);
      else chk("stream result", obs_out(), q.pop_front());
      npop++;
    end
    if (iv && in_ready) q.push_back(model(ia, ib, bi));
    @(negedge clk);
  endtask
  task automatic idle(input logic ordy);
    cyc(1'b0, 16'h0, 16'h0, 1'b0, ordy);
  endtask
  task automatic rnd(input logic iv, input logic ordy);
    cyc(iv, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), ordy);
  endtask
  task automatic dir(input string tag, input logic [15:0] ia, input logic [15:0] ib, input logic bi, input logic [17:0] ex);
    int lat;
    cyc(1'b1, ia, ib, bi, 1'b1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      idle(1'b1);
      lat++;
    end
    chk({tag, " latency"}, lat, 4);
    chk(tag, obs_out(), {14'd0, ex});
    idle(1'b1);
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset outputs", obs_out(), 0);
    rst_n = 1'b1;
    #1 chk("in_ready after reset", in_ready, 1);
    @(negedge clk);
    dir("5-3", 16'h0005, 16'h0003, 1'b0, {16'h0002, 1'b0, 1'b0});
    dir("8000-1", 16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1});
    dir("0-1", 16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0});
    dir("7FFF-FFFF", 16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 1'b1, 1'b1});
    dir("1000-0-bin", 16'h1000, 16'h0000, 1'b1, {16'h0FFF, 1'b0, 1'b0});
    dir("a==b", 16'h1234, 16'h1234, 1'b0, {16'h0000, 1'b0, 1'b0});
    dir("0-0-bin", 16'h0000, 16'h0000, 1'b1, {16'hFFFF, 1'b1, 1'b0});
    p0 = npop;
    for (int i = 0; i < 100; i++) begin
      if (i >= 4) chk("one result per clock", out_valid, 1);
      rnd(1'b1, 1'b1);
    end
    repeat (6) idle(1'b1);
    chk("stream count", npop - p0, 100);
    chk("stream drained", q.size(), 0);
    for (int i = 0; i < 4; i++) rnd(1'b1, 1'b0);
    chk("full out_valid", out_valid, 1);
    snap = obs_out();
    for (int i = 0; i < 5; i++) begin
      chk("stall in_ready", in_ready, 0);
      chk("stall outputs stable", obs_out(), snap);
      rnd(1'b1, 1'b0);
    end
    chk("stall still valid", out_valid, 1);
    chk("stall outputs final", obs_out(), snap);
    for (int i = 0; i < 80; i++) rnd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (8) idle(1'b1);
    chk("backpressure drained", q.size(), 0);
    for (int i = 0; i < 5; i++) rnd(1'b1, 1'b1);
    chk("pre-reset valid", out_valid, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset outputs", obs_out(), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("no stale result", out_valid, 0);
      idle(1'b1);
    end
    dir("post-reset", 16'h00FF, 16'h0F0F, 1'b0, {16'hF1F0, 1'b1, 1'b0});
    chk("final drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
